// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with parity/error detection and a first-word-fall-through receive FIFO
module uart_rx_fifo #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          err_clr,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overflow
);
  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int DW = $clog2(DIV + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_n;
  logic rx_m, rx_s, armed, tick, start_det, half_pt, full_pt;
  logic done, stop_ok, par_fault, par_exp, good, push, pop;
  logic [DW-1:0] div_cnt;
  logic [TW-1:0] tick_cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign tick = div_cnt == DW'(DIV - 1);
  assign start_det = state == IDLE && armed && !rx_s;
  assign half_pt = tick && tick_cnt == TW'(OVERSAMPLE / 2 - 1);
  assign full_pt = tick && tick_cnt == TW'(OVERSAMPLE - 1);
  assign par_exp = PARITY == 1 ? ~^shift : ^shift;
  assign busy = state != IDLE;
  assign good = done && stop_ok && !par_fault;
  assign push = good && (!full || rd_en);
  assign pop = rd_en && !empty;
  assign empty = count == '0;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign rd_data = empty ? '0 : mem[rd_ptr];
  // Two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge sysclk) {rx_s, rx_m} <= reset ? 2'b11 : {rx_m, rx};
  // State register
  always_ff @(posedge sysclk) state <= reset ? IDLE : state_n;
  // Next state: half-bit check of the start bit, then one sample per bit at mid-bit
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_det ? START : IDLE;
      START:   state_n = half_pt ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_n = full_pt && bit_cnt == BW'(DATA_BITS - 1) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = full_pt ? STOP : PAR;
      STOP:    state_n = full_pt ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // Bit timing aligned to the start edge, data shift-in and frame-completion bookkeeping
  always_ff @(posedge sysclk) begin
    if (reset) begin
      div_cnt <= '0;
      tick_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      armed <= 1'b0;
      par_fault <= 1'b0;
      done <= 1'b0;
      stop_ok <= 1'b0;
    end else begin
      div_cnt <= start_det || tick ? '0 : div_cnt + DW'(1);
      tick_cnt <= state == IDLE || state_n != state || full_pt ? '0 : tick ? tick_cnt + TW'(1) : tick_cnt;
      bit_cnt <= state == START ? '0 : state == DATA && full_pt ? bit_cnt + BW'(1) : bit_cnt;
      if (state == DATA && full_pt) shift <= {rx_s, shift[DATA_BITS-1:1]};
      armed <= start_det ? 1'b0 : state == IDLE ? armed | rx_s : armed;
      par_fault <= state == START ? 1'b0 : state == PAR && full_pt ? rx_s != par_exp : par_fault;
      done <= state == STOP && full_pt;
      if (state == STOP && full_pt) stop_ok <= rx_s;
    end
  end
  // Sticky error flags; a fresh error beats a simultaneous clear
  always_ff @(posedge sysclk) begin
    if (reset) begin
      frame_err <= 1'b0;
      parity_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      frame_err <= (done && !stop_ok) || (frame_err && !err_clr);
      parity_err <= (done && par_fault) || (parity_err && !err_clr);
      overflow <= (good && full && !rd_en) || (overflow && !err_clr);
    end
  end
  // FIFO pointers and occupancy
  always_ff @(posedge sysclk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      count <= count + (AW + 1)'(push) - (AW + 1)'(pop);
    end
  end
  // FIFO storage, written only on a push
  always_ff @(posedge sysclk) if (push) mem[wr_ptr] <= shift;
endmodule
